// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and lane helpers for the load/store unit.
// LSU_MISALIGNED_EN adds the READ2/WRITE2 states for accesses that span two words.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

`ifdef LSU_MISALIGNED_EN
  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, READ2, WRITE2} lsu_state_t;
`else
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} lsu_state_t;
`endif

  function automatic logic [31:0] word_shift_dn(logic [31:0] w, logic [1:0] off);
    return w >> {off, 3'b000};
  endfunction

  // Mask of the bytes touched by a store of size f3 starting at byte offset off.
  function automatic logic [31:0] lane_mask(logic [2:0] f3, logic [1:0] off);
    logic [31:0] m;
    case (f3[1:0])
      2'b00:   m = 32'h0000_00FF;
      2'b01:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m << {off, 3'b000};
  endfunction

  function automatic logic is_legal(logic we, logic [2:0] f3);
    if (we) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic is_aligned(logic [2:0] f3, logic [1:0] off);
    case (f3[1:0])
      2'b01:   return !off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// lsu_if: core request/response handshake plus the word-wide data memory port.
// master = core and memory side, slave = load_store_unit.
interface lsu_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_fault;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_we;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_address, mem_data_out, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_data_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_address, mem_data_out, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane extract/extend for loads and lane merge for sub-word stores.
// Latency: purely combinational. Backpressure: none, no state.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  st_off,
  input  logic [2:0]  st_funct3,
  output logic [31:0] st_word
);
  logic [31:0] ld_shift;
  logic [31:0] st_mask;
  logic [31:0] st_data;

  always_comb begin
    ld_shift = word_shift_dn(ld_word, ld_off);
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  assign st_mask = lane_mask(st_funct3, st_off);
  assign st_data = st_wdata << {st_off, 3'b000};
  assign st_word = (st_old & ~st_mask) | (st_data & st_mask);
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RISC-V LB..SW to word memory; sub-word stores via read-modify-write.
// Latency: fault +1, load/SW +2, SB/SH +3 (LSU_MISALIGNED_EN: misaligned load +3, store +5).
// Backpressure: req_ready only in IDLE, one transaction in flight at a time.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic reset,
  lsu_if.slave bus
);
  lsu_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic              fault_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] old_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              req_misal;
  logic              req_bad;
  logic [ADDR_W-1:0] word_addr;
  logic [DATA_W-1:0] ld_word;
  logic [1:0]        ld_off;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] st_word;

  assign accept    = bus.req_valid && (state == IDLE);
  assign req_misal = !is_aligned(bus.req_funct3, bus.req_addr[1:0]);
  assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGNED_EN
  logic              misal_q;
  logic [DATA_W-1:0] old2_q;
  logic [ADDR_W-1:0] next_addr;
  logic [63:0]       pair_shift;
  logic [63:0]       mask64;
  logic [63:0]       data64;
  logic [63:0]       merged64;

  assign req_bad   = !is_legal(bus.req_we, bus.req_funct3);
  assign next_addr = word_addr + ADDR_W'(4);
  // Spanning accesses treat {word A+4, word A} as one 64-bit little-endian window.
  assign pair_shift = {bus.mem_data_in, old_q} >> {addr_q[1:0], 3'b000};
  assign mask64     = {32'h0, lane_mask(f3_q, 2'b00)} << {addr_q[1:0], 3'b000};
  assign data64     = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
  assign merged64   = ({old2_q, old_q} & ~mask64) | (data64 & mask64);
  assign ld_word    = (state == READ2) ? pair_shift[31:0] : bus.mem_data_in;
  assign ld_off     = (state == READ2) ? 2'b00 : addr_q[1:0];
`else
  assign req_bad = !is_legal(bus.req_we, bus.req_funct3) || req_misal;
  assign ld_word = bus.mem_data_in;
  assign ld_off  = addr_q[1:0];
`endif

  lsu_align u_align (
    .ld_word   (ld_word),
    .ld_off    (ld_off),
    .ld_funct3 (f3_q),
    .ld_data   (ld_data),
    .st_old    (old_q),
    .st_wdata  (wdata_q),
    .st_off    (addr_q[1:0]),
    .st_funct3 (f3_q),
    .st_word   (st_word)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (req_bad)                                                 state_nxt = RESP;
          else if (bus.req_we && bus.req_funct3 == F3_W && !req_misal) state_nxt = WRITE;
          else                                                         state_nxt = READ;
        end
      end
`ifdef LSU_MISALIGNED_EN
      READ:   state_nxt = misal_q ? READ2 : (we_q ? WRITE : RESP);
      READ2:  state_nxt = we_q ? WRITE : RESP;
      WRITE:  state_nxt = misal_q ? WRITE2 : RESP;
      WRITE2: state_nxt = RESP;
`else
      READ:   state_nxt = we_q ? WRITE : RESP;
      WRITE:  state_nxt = RESP;
`endif
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = (state == IDLE);
    bus.rsp_valid    = (state == RESP);
    bus.rsp_rdata    = (state == RESP) ? rdata_q : '0;
    bus.rsp_fault    = (state == RESP) && fault_q;
    bus.mem_address  = '0;
    bus.mem_data_out = '0;
    bus.mem_we       = 1'b0;
    case (state)
      READ: bus.mem_address = word_addr;
      WRITE: begin
        bus.mem_address  = word_addr;
`ifdef LSU_MISALIGNED_EN
        bus.mem_data_out = misal_q ? merged64[31:0] : st_word;
`else
        bus.mem_data_out = st_word;
`endif
        bus.mem_we       = !reset;
      end
`ifdef LSU_MISALIGNED_EN
      READ2: bus.mem_address = next_addr;
      WRITE2: begin
        bus.mem_address  = next_addr;
        bus.mem_data_out = merged64[63:32];
        bus.mem_we       = !reset;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGNED_EN
      misal_q <= 1'b0;
      old2_q  <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= bus.req_addr;
        f3_q    <= bus.req_funct3;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
        fault_q <= req_bad;
        rdata_q <= '0;
`ifdef LSU_MISALIGNED_EN
        misal_q <= req_misal;
`endif
      end
      // A store's READ keeps the old word for the merge; a load's READ keeps the result.
      if (state == READ) begin
        old_q <= bus.mem_data_in;
        if (!we_q) rdata_q <= ld_data;
      end
`ifdef LSU_MISALIGNED_EN
      if (state == READ2) begin
        old2_q <= bus.mem_data_in;
        if (!we_q) rdata_q <= ld_data;
      end
`endif
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized check of load_store_unit against a byte-addressed reference memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  logic [7:0]  ref_mem [256];
  int n_chk = 0;
  int n_bad = 0;

  assign bus.mem_data_in = mem[bus.mem_address[7:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_address[7:2]] <= bus.mem_data_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int ref_size(logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic ref_legal(logic we, logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] ref_word(int addr);
    logic [31:0] v;
    int base;
    base = addr & 252;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = ref_mem[base + i];
    return v;
  endfunction

  function automatic logic [31:0] ref_load(int addr, logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = ref_size(f3);
    v = '0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = ref_mem[(addr + i) % 256];
    if (!f3[2] && sz < 4 && v[8*sz-1])
      for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic run_req(input logic we, input logic [2:0] f3, input int addr, input logic [31:0] wdata);
    int sz, guard, exp_lat, exp_we, exp_we_first, rsp_cyc, rsp_cnt, we_cnt, we_first;
    logic misal, exp_fault;
    logic [31:0] exp_rdata, got_rdata;
    logic got_fault;
    sz = ref_size(f3);
    misal = (addr % sz) != 0;
`ifdef LSU_MISALIGNED_EN
    exp_fault = !ref_legal(we, f3);
`else
    exp_fault = !ref_legal(we, f3) || misal;
`endif
    exp_rdata = '0;
    exp_we = 0;
    exp_we_first = 0;
    if (exp_fault) exp_lat = 1;
    else if (!we) begin
      exp_lat = misal ? 3 : 2;
      exp_rdata = ref_load(addr, f3);
    end else if (misal) begin
      exp_lat = 5; exp_we = 2; exp_we_first = 3;
    end else begin
      exp_lat = (sz == 4) ? 2 : 3; exp_we = 1; exp_we_first = exp_lat - 1;
    end

    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_funct3 = f3;
    bus.req_addr = 32'(addr);
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;

    rsp_cyc = 0; rsp_cnt = 0; we_cnt = 0; we_first = 0;
    got_rdata = '0; got_fault = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) check("busy_ready", 32'(bus.req_ready), 32'd0);
      if (bus.rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc == 0) begin
          rsp_cyc = k;
          got_rdata = bus.rsp_rdata;
          got_fault = bus.rsp_fault;
        end
      end
      if (bus.mem_we) begin
        we_cnt++;
        if (we_first == 0) we_first = k;
      end
    end
    check("rsp_latency", 32'(rsp_cyc), 32'(exp_lat));
    check("rsp_count", 32'(rsp_cnt), 32'd1);
    check("rsp_rdata", got_rdata, exp_rdata);
    check("rsp_fault", 32'(got_fault), 32'(exp_fault));
    check("mem_we_count", 32'(we_cnt), 32'(exp_we));
    if (exp_we > 0) check("mem_we_cycle", 32'(we_first), 32'(exp_we_first));

    if (we && !exp_fault)
      for (int i = 0; i < sz; i++) ref_mem[(addr + i) % 256] = wdata[8*i +: 8];
    check("mem_word", mem[addr / 4], ref_word(addr));
    check("mem_next_word", mem[((addr / 4) + 1) % 64], ref_word((addr + 4) % 256));
    check("idle_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int rsp_seen, bad_words;
    logic [31:0] w;
    logic we;
    logic [2:0] f3;
    logic [2:0] ld_codes [5];
    ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end
    w = 32'h8899AABB;
    mem[16] = w;
    for (int b = 0; b < 4; b++) ref_mem[64 + b] = w[8*b +: 8];

    repeat (3) @(negedge clk);
    check("reset_mem_we", 32'(bus.mem_we), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(bus.req_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_fault", 32'(bus.rsp_fault), 32'd0);
    check("reset_mem_address", bus.mem_address, 32'd0);
    check("reset_mem_data_out", bus.mem_data_out, 32'd0);

    run_req(1'b0, F3_B,  32'h41, 32'h0);
    run_req(1'b0, F3_BU, 32'h43, 32'h0);
    run_req(1'b0, F3_H,  32'h42, 32'h0);
    run_req(1'b0, F3_HU, 32'h40, 32'h0);
    run_req(1'b0, F3_W,  32'h40, 32'h0);
    run_req(1'b1, F3_B,  32'h42, 32'h123456CC);
    check("sb_result", mem[16], 32'h88CCAABB);
    run_req(1'b1, F3_W,  32'h44, 32'hDEADBEEF);
    run_req(1'b0, F3_W,  32'h44, 32'h0);
    run_req(1'b0, F3_W,  32'h46, 32'h0);
    run_req(1'b1, 3'b011, 32'h40, 32'hFFFFFFFF);

    // Reset lands while an SH sits in WRITE.
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr = 32'h4A;
    bus.req_wdata = 32'h00005555;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_write_pending", 32'(bus.mem_we), 32'd1);
    reset = 1'b1;
    #1 check("rst_we_gated", 32'(bus.mem_we), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rsp_seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (bus.rsp_valid) rsp_seen++;
      @(negedge clk);
    end
    check("rst_no_rsp", 32'(rsp_seen), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_mem_unchanged", mem[18], ref_word(32'h48));

    for (int n = 0; n < 200; n++) begin
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        f3 = we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
      else
        f3 = 3'($urandom_range(0, 7));
      run_req(we, f3, int'($urandom_range(0, 255)), $urandom);
    end

    bad_words = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_word(4*i)) bad_words++;
    check("final_mem_diff", 32'(bad_words), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
